if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the RV32I 5-stage pipeline; sits directly upstream of the IF/ID register.

---
 rtl/rv32i_types.sv | 14 +
 rtl/pc_register.sv | 26 ++
 rtl/if_fetch_stage.sv | 123 ++++++++++++
 tb/tb_if_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: machine word and fetch-stage state encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam rv32i_word PC_STEP   = 32'd4;
    localparam rv32i_word WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_register.sv
// Program counter register: loads a new PC when told to, async-resets to RESET_PC.
module pc_register
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h0000_0060
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  rv32i_word in,
    output rv32i_word out
);

    rv32i_word r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= in;
        end
    end

    assign out = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem read/resp handshake,
// buffers a response across downstream stalls and discards wrong-path fetches.
module if_fetch_stage
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h0000_0060
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      redirect,
    input  rv32i_word redirect_pc,
    output logic      imem_read,
    output rv32i_word imem_address,
    input  rv32i_word imem_rdata,
    input  logic      imem_resp,
    output logic      if_valid,
    output rv32i_word mem_rdata,
    output rv32i_word if_PC_out,
    output logic      ifid_load
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic         r_kill;
    logic         w_kill_next;
    rv32i_word    r_pend_pc;
    rv32i_word    w_pend_next;
    rv32i_word    r_buf_instr;
    rv32i_word    w_buf_next;
    logic         w_pc_load;
    rv32i_word    w_pc_in;
    rv32i_word    w_pc;
    rv32i_word    w_redirect_aligned;

    assign w_redirect_aligned = redirect_pc & WORD_MASK;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk  (clk),
        .rst  (rst),
        .load (w_pc_load),
        .in   (w_pc_in),
        .out  (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FETCH;
            r_kill      <= 1'b0;
            r_pend_pc   <= '0;
            r_buf_instr <= '0;
        end else begin
            r_state     <= w_next_state;
            r_kill      <= w_kill_next;
            r_pend_pc   <= w_pend_next;
            r_buf_instr <= w_buf_next;
        end
    end

    // A request already issued cannot be withdrawn, so a redirect during the wait
    // only arms kill; the PC moves once the stale response has been swallowed.
    always_comb begin
        w_next_state = r_state;
        w_kill_next  = r_kill;
        w_pend_next  = r_pend_pc;
        w_buf_next   = r_buf_instr;
        w_pc_load    = 1'b0;
        w_pc_in      = w_pc;
        imem_read    = 1'b0;
        if_valid     = 1'b0;
        mem_rdata    = '0;
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    imem_read = 1'b1;
                    if (imem_resp) begin
                        if (r_kill || redirect) begin
                            w_pc_load   = 1'b1;
                            w_pc_in     = redirect ? w_redirect_aligned : r_pend_pc;
                            w_kill_next = 1'b0;
                        end else begin
                            if_valid  = 1'b1;
                            mem_rdata = imem_rdata;
                            if (!stall) begin
                                w_pc_load = 1'b1;
                                w_pc_in   = w_pc + PC_STEP;
                            end else begin
                                w_buf_next   = imem_rdata;
                                w_next_state = HOLD;
                            end
                        end
                    end else if (redirect) begin
                        w_kill_next = 1'b1;
                        w_pend_next = w_redirect_aligned;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        w_pc_load    = 1'b1;
                        w_pc_in      = w_redirect_aligned;
                        w_next_state = FETCH;
                    end else begin
                        if_valid  = 1'b1;
                        mem_rdata = r_buf_instr;
                        if (!stall) begin
                            w_pc_load    = 1'b1;
                            w_pc_in      = w_pc + PC_STEP;
                            w_next_state = FETCH;
                        end
                    end
                end
                default: w_next_state = FETCH;
            endcase
        end
    end

    assign imem_address = w_pc;
    assign if_PC_out    = w_pc;
    assign ifid_load    = if_valid & ~stall;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: the bench plays instruction memory and keeps
// a scoreboard of instructions it expects IF/ID to capture.
module tb_if_fetch_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } sb_entry_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_read;
   logic [31:0] imem_address;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        if_valid;
   logic [31:0] mem_rdata;
   logic [31:0] if_PC_out;
   logic        ifid_load;

   sb_entry_t sbQueue[$];
   int        checks = 0;
   int        failures = 0;

   if_fetch_stage #(
      .RESET_PC (32'h0000_0060)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_read    (imem_read),
      .imem_address (imem_address),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .if_valid     (if_valid),
      .mem_rdata    (mem_rdata),
      .if_PC_out    (if_PC_out),
      .ifid_load    (ifid_load)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents are a fixed scramble of the address so every word differs.
   function automatic logic [31:0] instrFor(input logic [31:0] addr);
      return (addr * 32'd3) ^ 32'h1300_0013;
   endfunction

   // One comparison: counts it and reports tag/observed/expected on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drives one cycle's inputs just after a rising edge and lets the combinational outputs settle.
   task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic rsp, input logic [31:0] rdata);
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem_resp   = rsp;
      imem_rdata  = rdata;
      #4;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // IF/ID must load now; the captured pair must be the oldest scoreboard entry.
   task automatic checkConsume(input string tag);
      sb_entry_t e;
      checkOutput({tag, ".ifid_load"}, {31'd0, ifid_load}, 32'd1);
      if (ifid_load === 1'b1) begin
         if (sbQueue.size() == 0) begin
            checkOutput({tag, ".sb_empty"}, 32'd0, 32'd1);
         end else begin
            e = sbQueue.pop_front();
            checkOutput({tag, ".instr"}, mem_rdata, e.instr);
            checkOutput({tag, ".pc"}, if_PC_out, e.pc);
         end
      end
   endtask

   // Zero-wait fetch of addr: the response comes in the same cycle the request is seen.
   task automatic fetchZeroWait(input string tag, input logic [31:0] addr);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, instrFor(addr));
      sbQueue.push_back('{instr: instrFor(addr), pc: addr});
      checkOutput({tag, ".addr"}, imem_address, addr);
      checkOutput({tag, ".read"}, {31'd0, imem_read}, 32'd1);
      checkOutput({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
      checkConsume(tag);
      nextCycle();
   endtask

   // A cycle whose response must be thrown away.
   task automatic checkDropped(input string tag);
      checkOutput({tag, ".valid"}, {31'd0, if_valid}, 32'd0);
      checkOutput({tag, ".ifid_load"}, {31'd0, ifid_load}, 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      imem_resp   = 1'b0;
      imem_rdata  = 32'd0;

      // Reset values
      #2;
      checkOutput("rst.read", {31'd0, imem_read}, 32'd0);
      checkOutput("rst.valid", {31'd0, if_valid}, 32'd0);
      checkOutput("rst.ifid_load", {31'd0, ifid_load}, 32'd0);
      checkOutput("rst.rdata", mem_rdata, 32'd0);
      checkOutput("rst.pc", if_PC_out, 32'h60);
      @(posedge clk);
      #3 rst = 1'b0;
      nextCycle();

      // Back-to-back zero-wait fetches after reset
      for (int i = 0; i < 3; i++) begin
         fetchZeroWait($sformatf("seq%0d", i), 32'h60 + 32'(i) * 32'd4);
      end

      // Response under stall is held in the buffer until the stall drops
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, instrFor(32'h6C));
      sbQueue.push_back('{instr: instrFor(32'h6C), pc: 32'h6C});
      checkOutput("stallResp.valid", {31'd0, if_valid}, 32'd1);
      checkOutput("stallResp.ifid_load", {31'd0, ifid_load}, 32'd0);
      nextCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
         checkOutput($sformatf("hold%0d.read", i), {31'd0, imem_read}, 32'd0);
         checkOutput($sformatf("hold%0d.rdata", i), mem_rdata, instrFor(32'h6C));
         checkOutput($sformatf("hold%0d.addr", i), imem_address, 32'h6C);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      checkConsume("holdRelease");
      nextCycle();

      // Redirect during a 4-wait fetch of 0x70 kills that response
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
      checkOutput("kill.addr", imem_address, 32'h70);
      checkOutput("kill.read", {31'd0, imem_read}, 32'd1);
      nextCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
         checkOutput($sformatf("killWait%0d.addr", i), imem_address, 32'h70);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, instrFor(32'h70));
      checkDropped("killResp");
      nextCycle();
      fetchZeroWait("afterKill", 32'h200);

      // Two redirects in one wait: the later one wins and its low bits are cleared
      applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 32'h406, 1'b0, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, instrFor(32'h204));
      checkDropped("doubleRedir");
      nextCycle();
      fetchZeroWait("afterDouble", 32'h404);

      // Redirect coinciding with a response
      applyStimulus(1'b0, 1'b1, 32'h500, 1'b1, instrFor(32'h408));
      checkDropped("sameCycle");
      nextCycle();

      // Redirect while holding under stall
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, instrFor(32'h500));
      checkOutput("holdRedir.addr", imem_address, 32'h500);
      checkOutput("holdRedir.enterValid", {31'd0, if_valid}, 32'd1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h603, 1'b0, 32'd0);
      checkDropped("holdRedir");
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      checkOutput("holdRedir.next", imem_address, 32'h600);
      checkOutput("holdRedir.read", {31'd0, imem_read}, 32'd1);

      // PC wraps past the top of the address space
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, instrFor(32'h600));
      checkDropped("toTop");
      nextCycle();
      fetchZeroWait("top", 32'hFFFF_FFFC);

      // Asynchronous reset in the middle of a wait
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      checkOutput("wrap.addr", imem_address, 32'h0);
      checkOutput("wrap.read", {31'd0, imem_read}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("asyncRst.read", {31'd0, imem_read}, 32'd0);
      checkOutput("asyncRst.valid", {31'd0, if_valid}, 32'd0);
      checkOutput("asyncRst.addr", imem_address, 32'h60);
      nextCycle();
      rst = 1'b0;
      nextCycle();
      fetchZeroWait("restart", 32'h60);

      checkOutput("sb.leftover", sbQueue.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
